// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access sequencer.
package dmem_access_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) == 2'b00;
  endfunction
endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/acknowledge bus between the access sequencer (master) and the data memory (slave).
interface dmem_access_ctrl_if
  import dmem_access_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/dmem_wait_timer.sv
// 8-bit wait counter; flags the last ACCESS cycle allowed before giving up on the memory.
module dmem_wait_timer #(
  parameter logic [7:0] MAX_WAIT = 8'd64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);
  logic [7:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Fires while the MAX_WAIT-th enabled cycle is in progress, so the exit edge is that cycle's end.
  assign o_timeout = i_en && (r_cnt == (MAX_WAIT - 8'd1));
endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequencer between the MEM stage and a multi-cycle req/ack data memory; stalls the pipeline per access.
// Optional macro DMEM_STALL_CNT_EN adds a saturating stall-cycle counter output stall_cnt_o.
module dmem_access_ctrl
  import dmem_access_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              stall_o,
  output logic              err_o,
`ifdef DMEM_STALL_CNT_EN
  output logic [31:0]       stall_cnt_o,
`endif
  dmem_access_ctrl_if.master mem_if
);
  state_e            r_state;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              w_aligned;
  logic              w_timeout;
  logic              w_clr;
  logic              w_en;

  assign w_aligned = is_aligned(cpu_addr_i[1:0]);
  assign w_clr     = (r_state == IDLE);
  assign w_en      = (r_state == ACCESS);

  dmem_wait_timer #(.MAX_WAIT(8'(MAX_WAIT))) u_wait_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_clr     (w_clr),
    .i_en      (w_en),
    .o_timeout (w_timeout)
  );

  // Gated by reset so every output reads 0 while reset is held.
  assign stall_o = rst_i & ((r_state == ACCESS) | ((r_state == IDLE) & cpu_req_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= IDLE;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_req_i) begin
            if (w_aligned) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= cpu_we_i;
              r_mem_addr  <= cpu_addr_i;
              r_mem_wdata <= cpu_wdata_i;
              r_state     <= ACCESS;
            end else begin
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_state <= DONE;
            end
          end
        end
        ACCESS: begin
          // Ack takes priority over a coincident timeout.
          if (mem_if.mem_ack_i) begin
            if (!r_mem_we) r_rdata <= mem_if.mem_rdata_i;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= DONE;
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_err     <= 1'b1;
            r_rdata   <= '0;
            r_state   <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_rdata_o        = r_rdata;
  assign err_o              = r_err;
  assign mem_if.mem_req_o   = r_mem_req;
  assign mem_if.mem_we_o    = r_mem_we;
  assign mem_if.mem_addr_o  = r_mem_addr;
  assign mem_if.mem_wdata_o = r_mem_wdata;

`ifdef DMEM_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (stall_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus randomized transactions against a transaction-level model.
module tb_dmem_access_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cpu_req_i;
  logic          cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i;
  logic [DW-1:0] cpu_rdata_o;
  logic          stall_o;
  logic          err_o;
`ifdef DMEM_STALL_CNT_EN
  logic [31:0]   stall_cnt_o;
`endif

  dmem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  dmem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .stall_o     (stall_o),
    .err_o       (err_o),
`ifdef DMEM_STALL_CNT_EN
    .stall_cnt_o (stall_cnt_o),
`endif
    .mem_if      (mem_if.master)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: last returned load data, sticky error, stall cycles since reset.
  logic [DW-1:0] m_rdata;
  logic          m_err;
  int            m_stall;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample(input string ph, input logic exp_stall, input logic exp_req);
    @(negedge clk_i);
    chk_eq({ph, ".stall"}, 32'(stall_o), 32'(exp_stall));
    chk_eq({ph, ".req"}, 32'(mem_if.mem_req_o), 32'(exp_req));
`ifdef DMEM_STALL_CNT_EN
    chk_eq({ph, ".stall_cnt"}, stall_cnt_o, 32'(m_stall));
`endif
    if (exp_stall) m_stall++;
  endtask

  task automatic apply_reset();
    rst_i = 1'b0;
    #1;
    chk_eq("rst.rdata", cpu_rdata_o, 32'h0);
    chk_eq("rst.stall", 32'(stall_o), 32'h0);
    chk_eq("rst.err", 32'(err_o), 32'h0);
    chk_eq("rst.req", 32'(mem_if.mem_req_o), 32'h0);
    chk_eq("rst.we", 32'(mem_if.mem_we_o), 32'h0);
    chk_eq("rst.addr", mem_if.mem_addr_o, 32'h0);
    chk_eq("rst.wdata", mem_if.mem_wdata_o, 32'h0);
`ifdef DMEM_STALL_CNT_EN
    chk_eq("rst.stall_cnt", stall_cnt_o, 32'h0);
`endif
    m_rdata = '0;
    m_err   = 1'b0;
    m_stall = 0;
    cpu_req_i = 1'b0;
    mem_if.mem_ack_i = 1'b0;
    next_cyc();
    rst_i = 1'b1;
  endtask

  task automatic idle_cyc(input logic ack);
    cpu_req_i = 1'b0;
    mem_if.mem_ack_i   = ack;
    mem_if.mem_rdata_i = $urandom;
    sample("idle", 1'b0, 1'b0);
    chk_eq("idle.rdata", cpu_rdata_o, m_rdata);
    chk_eq("idle.err", 32'(err_o), 32'(m_err));
    next_cyc();
  endtask

  // One memory instruction; k = ACCESS cycle carrying the ack (0 or >MW: no ack in window).
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] rdata, input int k, input logic hold_req);
    logic mis;
    logic ack_ok;
    int   acc;
    mis    = (addr[1:0] != 2'b00);
    ack_ok = (k >= 1) && (k <= MW);
    acc    = ack_ok ? k : MW;

    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata;
    mem_if.mem_ack_i = 1'b0;
    sample("req", 1'b1, 1'b0);
    next_cyc();

    if (!mis) begin
      for (int c = 1; c <= acc; c++) begin
        mem_if.mem_ack_i   = ack_ok && (c == k);
        mem_if.mem_rdata_i = (ack_ok && (c == k)) ? rdata : $urandom;
        cpu_req_i   = 1'($urandom);
        cpu_we_i    = 1'($urandom);
        cpu_addr_i  = $urandom;
        cpu_wdata_i = $urandom;
        sample("access", 1'b1, 1'b1);
        chk_eq("access.we", 32'(mem_if.mem_we_o), 32'(we));
        chk_eq("access.addr", mem_if.mem_addr_o, addr);
        chk_eq("access.wdata", mem_if.mem_wdata_o, wdata);
        next_cyc();
      end
    end

    if (mis || !ack_ok) begin
      m_err   = 1'b1;
      m_rdata = '0;
    end else if (!we) begin
      m_rdata = rdata;
    end

    mem_if.mem_ack_i = 1'b0;
    cpu_req_i = hold_req; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata;
    sample("done", 1'b0, 1'b0);
    chk_eq("done.we", 32'(mem_if.mem_we_o), 32'h0);
    chk_eq("done.rdata", cpu_rdata_o, m_rdata);
    chk_eq("done.err", 32'(err_o), 32'(m_err));
    next_cyc();
  endtask

  initial begin
    logic [AW-1:0] a;
    rst_i = 1'b1;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    mem_if.mem_ack_i = 1'b0; mem_if.mem_rdata_i = '0;
    m_rdata = '0; m_err = 1'b0; m_stall = 0;
    next_cyc();
    apply_reset();

    run_txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3, 1'b0);
    idle_cyc(1'b0);
    run_txn(1'b1, 32'h0000_0020, 32'h1234_5678, 32'hCAFE_F00D, 1, 1'b0);
    idle_cyc(1'b0);
    run_txn(1'b0, 32'h0000_0030, 32'h0, 32'h0BAD_F00D, MW, 1'b0);

    // Reset while a request is outstanding; a stray ack afterwards must be ignored.
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h80;
    sample("mid.req", 1'b1, 1'b0);
    next_cyc();
    sample("mid.access", 1'b1, 1'b1);
    next_cyc();
    apply_reset();
    idle_cyc(1'b1);
    idle_cyc(1'b0);

    run_txn(1'b0, 32'h0000_0040, 32'h0, 32'h5555_AAAA, 0, 1'b0);
    idle_cyc(1'b0);
    idle_cyc(1'b1);
    idle_cyc(1'b0);

    apply_reset();
    run_txn(1'b0, 32'h0000_0013, 32'h0, 32'h7777_7777, 2, 1'b0);
    idle_cyc(1'b0);

    apply_reset();
    run_txn(1'b0, 32'h0000_0000, 32'h0, 32'h1111_1111, 1, 1'b1);
    run_txn(1'b0, 32'h0000_0004, 32'h0, 32'h2222_2222, 1, 1'b0);
`ifdef DMEM_STALL_CNT_EN
    chk_eq("b2b.stall_cnt", stall_cnt_o, 32'd4);
`endif
    idle_cyc(1'b0);

    for (int t = 0; t < 300; t++) begin
      if ((t % 40) == 0) apply_reset();
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      run_txn(1'($urandom), a, $urandom, $urandom, int'($urandom_range(0, MW + 2)), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cyc(1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
